// File: rtl/vai_mgr_csr_pkg.sv
// Purpose : shared qword map, manager ID and VMID type for the VAI manager CSR block.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package vai_mgr_csr_pkg;

  // Qword indices inside the 512-qword control window.
  localparam logic [8:0] DFH         = 9'h000;
  localparam logic [8:0] ID_LO       = 9'h001;
  localparam logic [8:0] ID_HI       = 9'h002;
  localparam logic [8:0] RESET       = 9'h003;
  localparam logic [8:0] NAFUS       = 9'h004;
  localparam logic [8:0] CTRL        = 9'h005;
  localparam logic [8:0] RST_CYCLES  = 9'h006;
  localparam logic [8:0] OFFSET_BASE = 9'h010;
  localparam logic [8:0] DBG         = 9'h020;
  localparam logic [8:0] C0CNT_BASE  = 9'h040;
  localparam logic [8:0] C1CNT_BASE  = 9'h060;

  localparam logic [127:0] MGR_ID = 128'hd1d383aaca4c4c60_a0a013a421139e6a;

  // Wide enough for the largest legal sub-AFU count (32).
  typedef logic [4:0] t_vmid;

endpackage

// File: rtl/vai_reset_timer.sv
// Purpose : one sub-AFU reset bit with an auto-clear down-counter.
// Latency : rst_out follows a load on the next clock; auto-clear after 'cycles' clocks.
// Backpressure: none; a load is always accepted and beats a same-cycle expiry.
// Ports   : clk, rst (sync, active high), load/load_bit (software write of this bit),
//           cycles (auto-clear length, 0 = hold), rst_out (registered reset bit).
module vai_reset_timer
  import vai_mgr_csr_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               load_bit,
  input  logic [TIMER_W-1:0] cycles,
  output logic               rst_out
);

  logic               bit_q, bit_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_d = bit_q;
    cnt_d = cnt_q;
    if (load) begin
      // Writing 0 clears and stops; writing 1 with cycles==0 leaves cnt at 0 so the bit holds.
      bit_d = load_bit;
      cnt_d = load_bit ? cycles : '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
      if (cnt_q == TIMER_W'(1)) bit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bit_q <= bit_d;
      cnt_q <= cnt_d;
    end
  end

  assign rst_out = bit_q;

endmodule

// File: rtl/vai_mgr_csr.sv
// Purpose : VAI manager control-MMIO CSR window: DFH/ID, sub-AFU offsets, timed sub-AFU
//           resets and per-VMID saturating c0/c1 TX counters.
// Latency : read request sampled at T -> rsp_valid at T+3; write visible to reads issued at T+1.
// Backpressure: none; one request per cycle, write wins if rd and wr arrive together.
// Ports   : pClk / pck_cp2af_softReset (sync, active high); mmio_* request in;
//           tx_c0_* / tx_c1_* counter events; rsp_* read response out;
//           offset_array, sub_afu_reset per-VMID outputs.
// Option  : VAI_MGR_CSR_DBG_EN adds input dbg[63:0], readable at qword 0x20, DFH bit41 = 1.
module vai_mgr_csr
  import vai_mgr_csr_pkg::*;
#(
  parameter int NUM_SUB_AFUS = 8,
  parameter int COUNTER_W    = 48,
  parameter int ADDR_W       = 16,
  parameter int RST_TIMER_W  = 16,
  localparam int VMID_W      = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1
) (
  input  logic              pClk,
  input  logic              pck_cp2af_softReset,
  input  logic              mmio_rd_valid,
  input  logic              mmio_wr_valid,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [63:0]       mmio_wdata,
  input  logic              tx_c0_valid,
  input  logic [VMID_W-1:0] tx_c0_vmid,
  input  logic              tx_c1_valid,
  input  logic [VMID_W-1:0] tx_c1_vmid,
`ifdef VAI_MGR_CSR_DBG_EN
  input  logic [63:0]       dbg,
`endif
  output logic              rsp_valid,
  output logic [8:0]        rsp_tid,
  output logic [63:0]       rsp_data,
  output logic [63:0]       offset_array [NUM_SUB_AFUS],
  output logic [NUM_SUB_AFUS-1:0] sub_afu_reset
);

  localparam int QA_W = ADDR_W - 1;

`ifdef VAI_MGR_CSR_DBG_EN
  localparam logic DBG_BIT = 1'b1;
`else
  localparam logic DBG_BIT = 1'b0;
`endif
  localparam logic [63:0] DFH_VAL = {4'h1, 18'b0, DBG_BIT, 1'b1, 40'b0};

  logic rst;
  assign rst = pck_cp2af_softReset;

  // Dword address LSB is irrelevant for qword registers.
  logic unused_addr_lsb;
  assign unused_addr_lsb = mmio_addr[0];

  // ---------------- pipeline registers ----------------
  logic            s1_vld_q, s1_vld_d, s1_wr_q, s1_wr_d;
  logic [QA_W-1:0] s1_qaddr_q, s1_qaddr_d;
  logic [8:0]      s1_tid_q, s1_tid_d;
  logic [63:0]     s1_wdata_q, s1_wdata_d;

  logic            s2_rd_q, s2_rd_d, s2_wr_q, s2_wr_d;
  logic [8:0]      s2_qidx_q, s2_qidx_d, s2_tid_q, s2_tid_d;
  logic [63:0]     s2_wdata_q, s2_wdata_d;

  logic            s3_rd_q, s3_rd_d;
  logic [8:0]      s3_qidx_q, s3_qidx_d, s3_tid_q, s3_tid_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [8:0]      rsp_tid_q, rsp_tid_d;
  logic [63:0]     rsp_data_q, rsp_data_d;

  // ---------------- architectural state ----------------
  logic [63:0]            offset_q [NUM_SUB_AFUS];
  logic [63:0]            offset_d [NUM_SUB_AFUS];
  logic [RST_TIMER_W-1:0] rst_cycles_q, rst_cycles_d;
  logic                   freeze_q, freeze_d;
  logic [COUNTER_W-1:0]   c0_cnt_q [NUM_SUB_AFUS];
  logic [COUNTER_W-1:0]   c0_cnt_d [NUM_SUB_AFUS];
  logic [COUNTER_W-1:0]   c1_cnt_q [NUM_SUB_AFUS];
  logic [COUNTER_W-1:0]   c1_cnt_d [NUM_SUB_AFUS];
`ifdef VAI_MGR_CSR_DBG_EN
  logic [63:0]            dbg_q, dbg_d;
`endif

  logic        in_win;
  logic        wr_reset;
  logic        clr_pulse;
  logic [63:0] rd_mux;

  // Control window is the first 1024 dwords; anything above is silently dropped.
  assign in_win   = (s1_qaddr_q >> 9) == '0;
  assign wr_reset = s2_wr_q && (s2_qidx_q == RESET);

  // ---------------- request pipeline ----------------
  always_comb begin
    s1_vld_d   = mmio_rd_valid | mmio_wr_valid;
    s1_wr_d    = mmio_wr_valid;
    s1_qaddr_d = mmio_addr[ADDR_W-1:1];
    s1_tid_d   = mmio_tid;
    s1_wdata_d = mmio_wdata;

    s2_rd_d    = s1_vld_q && !s1_wr_q && in_win;
    s2_wr_d    = s1_vld_q &&  s1_wr_q && in_win;
    s2_qidx_d  = s1_qaddr_q[8:0];
    s2_tid_d   = s1_tid_q;
    s2_wdata_d = s1_wdata_q;

    s3_rd_d    = s2_rd_q;
    s3_qidx_d  = s2_qidx_q;
    s3_tid_d   = s2_tid_q;

    rsp_valid_d = s3_rd_q;
    rsp_tid_d   = s3_tid_q;
    rsp_data_d  = s3_rd_q ? rd_mux : '0;
  end

  // ---------------- register writes (commit from S2) ----------------
  always_comb begin
    offset_d     = offset_q;
    rst_cycles_d = rst_cycles_q;
    freeze_d     = freeze_q;
    clr_pulse    = 1'b0;
    if (s2_wr_q) begin
      if (s2_qidx_q == CTRL) begin
        freeze_d  = s2_wdata_q[1];
        clr_pulse = s2_wdata_q[0];
      end
      if (s2_qidx_q == RST_CYCLES) rst_cycles_d = s2_wdata_q[RST_TIMER_W-1:0];
      for (int v = 0; v < NUM_SUB_AFUS; v++) begin
        if (s2_qidx_q == OFFSET_BASE + 9'(v)) offset_d[v] = s2_wdata_q;
      end
    end
  end

`ifdef VAI_MGR_CSR_DBG_EN
  always_comb dbg_d = dbg;
`endif

  // ---------------- TX counters ----------------
  always_comb begin
    c0_cnt_d = c0_cnt_q;
    c1_cnt_d = c1_cnt_q;
    for (int v = 0; v < NUM_SUB_AFUS; v++) begin
      if (clr_pulse) begin
        // Clear beats a same-cycle increment.
        c0_cnt_d[v] = '0;
        c1_cnt_d[v] = '0;
      end else if (!freeze_q) begin
        // Out-of-range VMIDs never match any v, so they are dropped here.
        if (tx_c0_valid && (t_vmid'(tx_c0_vmid) == t_vmid'(v)) && (c0_cnt_q[v] != '1))
          c0_cnt_d[v] = c0_cnt_q[v] + COUNTER_W'(1);
        if (tx_c1_valid && (t_vmid'(tx_c1_vmid) == t_vmid'(v)) && (c1_cnt_q[v] != '1))
          c1_cnt_d[v] = c1_cnt_q[v] + COUNTER_W'(1);
      end
    end
  end

  // ---------------- read mux (S3) ----------------
  always_comb begin
    rd_mux = '1;
    case (s3_qidx_q)
      DFH:        rd_mux = DFH_VAL;
      ID_LO:      rd_mux = MGR_ID[63:0];
      ID_HI:      rd_mux = MGR_ID[127:64];
      RESET:      rd_mux = 64'(sub_afu_reset);
      NAFUS:      rd_mux = 64'(NUM_SUB_AFUS);
      CTRL:       rd_mux = {62'b0, freeze_q, 1'b0};
      RST_CYCLES: rd_mux = 64'(rst_cycles_q);
      default:    rd_mux = '1;
    endcase
    for (int v = 0; v < NUM_SUB_AFUS; v++) begin
      if (s3_qidx_q == OFFSET_BASE + 9'(v)) rd_mux = offset_q[v];
      if (s3_qidx_q == C0CNT_BASE + 9'(v))  rd_mux = 64'(c0_cnt_q[v]);
      if (s3_qidx_q == C1CNT_BASE + 9'(v))  rd_mux = 64'(c1_cnt_q[v]);
    end
`ifdef VAI_MGR_CSR_DBG_EN
    // With more than 16 sub-AFUs this shadows the read of offset[16].
    if (s3_qidx_q == DBG) rd_mux = dbg_q;
`endif
  end

  // ---------------- flops ----------------
  always_ff @(posedge pClk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_wr_q      <= 1'b0;
      s1_qaddr_q   <= '0;
      s1_tid_q     <= '0;
      s1_wdata_q   <= '0;
      s2_rd_q      <= 1'b0;
      s2_wr_q      <= 1'b0;
      s2_qidx_q    <= '0;
      s2_tid_q     <= '0;
      s2_wdata_q   <= '0;
      s3_rd_q      <= 1'b0;
      s3_qidx_q    <= '0;
      s3_tid_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_tid_q    <= '0;
      rsp_data_q   <= '0;
      rst_cycles_q <= '0;
      freeze_q     <= 1'b0;
      for (int v = 0; v < NUM_SUB_AFUS; v++) begin
        offset_q[v] <= '0;
        c0_cnt_q[v] <= '0;
        c1_cnt_q[v] <= '0;
      end
`ifdef VAI_MGR_CSR_DBG_EN
      dbg_q        <= '0;
`endif
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_wr_q      <= s1_wr_d;
      s1_qaddr_q   <= s1_qaddr_d;
      s1_tid_q     <= s1_tid_d;
      s1_wdata_q   <= s1_wdata_d;
      s2_rd_q      <= s2_rd_d;
      s2_wr_q      <= s2_wr_d;
      s2_qidx_q    <= s2_qidx_d;
      s2_tid_q     <= s2_tid_d;
      s2_wdata_q   <= s2_wdata_d;
      s3_rd_q      <= s3_rd_d;
      s3_qidx_q    <= s3_qidx_d;
      s3_tid_q     <= s3_tid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tid_q    <= rsp_tid_d;
      rsp_data_q   <= rsp_data_d;
      rst_cycles_q <= rst_cycles_d;
      freeze_q     <= freeze_d;
      offset_q     <= offset_d;
      c0_cnt_q     <= c0_cnt_d;
      c1_cnt_q     <= c1_cnt_d;
`ifdef VAI_MGR_CSR_DBG_EN
      dbg_q        <= dbg_d;
`endif
    end
  end

  // ---------------- per-VMID reset timers ----------------
  for (genvar v = 0; v < NUM_SUB_AFUS; v++) begin : g_rst_timer
    vai_reset_timer #(
      .TIMER_W(RST_TIMER_W)
    ) u_timer (
      .clk     (pClk),
      .rst     (rst),
      .load    (wr_reset),
      .load_bit(s2_wdata_q[v]),
      .cycles  (rst_cycles_q),
      .rst_out (sub_afu_reset[v])
    );
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_tid      = rsp_tid_q;
  assign rsp_data     = rsp_data_q;
  assign offset_array = offset_q;

endmodule
